// File: rtl/switch_bank_seq.sv
// Break-before-make sequencer for a bank of short-circuit switches (at most one shorted at a time).
// Optional automatic sweep over all channels is built when SWITCH_BANK_SWEEP_EN is defined.
module switch_bank_seq #(
  parameter int CHANNELS = 4,
  parameter int SETTLE   = 8,
  localparam int SELW    = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [SELW-1:0]     req_ch,
  input  logic                req_open,
`ifdef SWITCH_BANK_SWEEP_EN
  input  logic                sweep_start,
`endif
  output logic [CHANNELS-1:0] sw_en,
  output logic                busy,
  output logic                done,
  output logic                err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BREAK = 2'd1,
    S_MAKE  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [CHANNELS-1:0] ONE      = CHANNELS'(1);
  localparam logic [7:0]          CNT_LOAD = 8'(SETTLE - 1);
  localparam logic [SELW-1:0]     CH_LAST  = SELW'(CHANNELS - 1);

  state_t          state;
  logic [7:0]      cnt;
  logic [SELW-1:0] ch_q;
  logic            open_q;
  logic            accept;
  logic            ch_legal;
  logic            same_ch;
  logic            sweep_go;

`ifdef SWITCH_BANK_SWEEP_EN
  logic            sweep_act;
  assign sweep_go = (state == S_IDLE) && req_ready && sweep_start;
`else
  assign sweep_go = 1'b0;
`endif

  assign accept   = (state == S_IDLE) && req_ready && req_valid && !sweep_go;
  assign ch_legal = int'(req_ch) < CHANNELS;
  // Out-of-range indices shift the one-hot mask to zero, so they never match.
  assign same_ch  = (sw_en & (ONE << req_ch)) != '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      ch_q      <= '0;
      open_q    <= 1'b0;
      sw_en     <= '0;
      req_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
`ifdef SWITCH_BANK_SWEEP_EN
      sweep_act <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          req_ready <= 1'b1;
          busy      <= 1'b0;
          if (sweep_go) begin
`ifdef SWITCH_BANK_SWEEP_EN
            sweep_act <= 1'b1;
`endif
            ch_q      <= '0;
            open_q    <= 1'b0;
            state     <= S_BREAK;
            sw_en     <= '0;
            cnt       <= CNT_LOAD;
            busy      <= 1'b1;
            req_ready <= 1'b0;
          end else if (accept) begin
            if (!req_open && !ch_legal) begin
              err <= 1'b1;
            end else if (!req_open && same_ch) begin
              state     <= S_DONE;
              done      <= 1'b1;
              busy      <= 1'b1;
              req_ready <= 1'b0;
            end else begin
              ch_q      <= req_ch;
              open_q    <= req_open;
              state     <= S_BREAK;
              sw_en     <= '0;
              cnt       <= CNT_LOAD;
              busy      <= 1'b1;
              req_ready <= 1'b0;
            end
          end
        end

        S_BREAK: begin
          if (cnt == 8'd0) begin
            if (open_q) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_MAKE;
              sw_en <= ONE << ch_q;
              cnt   <= CNT_LOAD;
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        S_MAKE: begin
          if (cnt == 8'd0) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        S_DONE: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
`ifdef SWITCH_BANK_SWEEP_EN
          // A sweep chains straight into the next break; the final step opens everything.
          if (sweep_act) begin
            if (open_q) begin
              sweep_act <= 1'b0;
            end else begin
              if (ch_q == CH_LAST) begin
                open_q <= 1'b1;
              end else begin
                ch_q <= ch_q + 1'b1;
              end
              state     <= S_BREAK;
              sw_en     <= '0;
              cnt       <= CNT_LOAD;
              req_ready <= 1'b0;
              busy      <= 1'b1;
            end
          end
`endif
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_switch_bank_seq.sv
// Bench for switch_bank_seq: one instance at CHANNELS=4/SETTLE=3 and one at CHANNELS=6/SETTLE=2,
// checked cycle by cycle against a transaction-level model of the switching rules.
module tb_switch_bank_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       valid_a = 1'b0, open_a = 1'b0;
  logic [1:0] ch_a = '0;
  logic       ready_a, busy_a, done_a, err_a;
  logic [3:0] sw_a;

  logic       valid_b = 1'b0, open_b = 1'b0;
  logic [2:0] ch_b = '0;
  logic       ready_b, busy_b, done_b, err_b;
  logic [5:0] sw_b;

`ifdef SWITCH_BANK_SWEEP_EN
  logic       sweep_a = 1'b0;
`endif

  int errors = 0;
  int checks = 0;
  int cur[2] = '{-1, -1};

  always #5 clk = ~clk;

  switch_bank_seq #(.CHANNELS(4), .SETTLE(3)) dut_a (
    .clk(clk), .rst(rst), .req_valid(valid_a), .req_ready(ready_a),
    .req_ch(ch_a), .req_open(open_a),
`ifdef SWITCH_BANK_SWEEP_EN
    .sweep_start(sweep_a),
`endif
    .sw_en(sw_a), .busy(busy_a), .done(done_a), .err(err_a));

  switch_bank_seq #(.CHANNELS(6), .SETTLE(2)) dut_b (
    .clk(clk), .rst(rst), .req_valid(valid_b), .req_ready(ready_b),
    .req_ch(ch_b), .req_open(open_b),
`ifdef SWITCH_BANK_SWEEP_EN
    .sweep_start(1'b0),
`endif
    .sw_en(sw_b), .busy(busy_b), .done(done_b), .err(err_b));

  function automatic int nch(input int which);
    return (which == 0) ? 4 : 6;
  endfunction

  function automatic int nsettle(input int which);
    return (which == 0) ? 3 : 2;
  endfunction

  // {sw_en padded to 16, req_ready, busy, done, err}
  function automatic logic [19:0] obs(input int which);
    logic [15:0] sw;
    sw = '0;
    if (which == 0) begin
      sw[3:0] = sw_a;
      return {sw, ready_a, busy_a, done_a, err_a};
    end
    sw[5:0] = sw_b;
    return {sw, ready_b, busy_b, done_b, err_b};
  endfunction

  function automatic logic [19:0] pack(input int sw, input bit rdy, input bit bsy,
                                       input bit dn, input bit er);
    return {16'(sw), rdy, bsy, dn, er};
  endfunction

  function automatic int mask(input int ch);
    return (ch >= 0) ? (1 << ch) : 0;
  endfunction

  task automatic drive(input int which, input bit v, input int ch, input bit op);
    if (which == 0) begin
      valid_a = v; ch_a = 2'(ch); open_a = op;
    end else begin
      valid_b = v; ch_b = 3'(ch); open_b = op;
    end
  endtask

  // One request, checked every cycle until the block is back in IDLE.
  // With hold set, req_valid stays high (other channel) while busy and must be ignored.
  task automatic do_req(input string name, input int which, input int ch, input bit op,
                        input bit hold);
    int c, s, kind, n, dcyc, exp_sw;
    logic [19:0] exp_v, got;
    c = nch(which);
    s = nsettle(which);
    if (!op && ch >= c)               kind = 0;
    else if (!op && cur[which] == ch) kind = 1;
    else if (op)                      kind = 3;
    else                              kind = 2;
    dcyc = (kind == 2) ? 2 * s + 1 : (kind == 3) ? s + 1 : 1;
    n    = (kind == 0) ? 2 : dcyc + 1;
    @(negedge clk);
    drive(which, 1'b1, ch, op);
    @(negedge clk);
    if (hold) drive(which, 1'b1, (ch + 1) % c, 1'b0);
    else      drive(which, 1'b0, 0, 1'b0);
    for (int k = 1; k <= n; k++) begin
      case (kind)
        0: exp_v = pack(mask(cur[which]), 1'b1, 1'b0, 1'b0, k == 1);
        1: exp_v = pack(mask(cur[which]), k > dcyc, k <= dcyc, k == dcyc, 1'b0);
        2: begin
          exp_sw = (k <= s) ? 0 : mask(ch);
          exp_v  = pack(exp_sw, k > dcyc, k <= dcyc, k == dcyc, 1'b0);
        end
        default: exp_v = pack(0, k > dcyc, k <= dcyc, k == dcyc, 1'b0);
      endcase
      got = obs(which);
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL %s inst=%0d cycle=%0d actual={sw,rdy,bsy,dn,er}=%h expected=%h",
                 name, which, k, got, exp_v);
      end
      if (k == n) drive(which, 1'b0, 0, 1'b0);
      else @(negedge clk);
    end
    if (kind == 2) cur[which] = ch;
    else if (kind == 3) cur[which] = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      checks++;
      if (obs(w) !== 20'h0) begin
        errors++;
        $display("FAIL reset_hold inst=%0d actual=%h expected=%h", w, obs(w), 20'h0);
      end
    end
    rst = 1'b0;
    #1;
    checks++;
    if (ready_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_pre_edge actual=%b expected=0", ready_a);
    end
    @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      checks++;
      if (obs(w) !== pack(0, 1'b1, 1'b0, 1'b0, 1'b0)) begin
        errors++;
        $display("FAIL reset_ready inst=%0d actual=%h expected=%h", w, obs(w),
                 pack(0, 1'b1, 1'b0, 1'b0, 1'b0));
      end
    end
    cur[0] = -1;
    cur[1] = -1;
  endtask

  task automatic test_directed();
    do_req("switch_ch2", 0, 2, 1'b0, 1'b0);
    do_req("switch_ch2_to_ch1", 0, 1, 1'b0, 1'b0);
    do_req("same_ch1", 0, 1, 1'b0, 1'b0);
    do_req("open_all", 0, 0, 1'b1, 1'b0);
    do_req("open_when_open", 0, 3, 1'b1, 1'b0);
  endtask

  task automatic test_illegal();
    do_req("illegal_ch6_idle", 1, 6, 1'b0, 1'b0);
    do_req("switch_b_ch5", 1, 5, 1'b0, 1'b0);
    do_req("illegal_ch7_keeps_sw", 1, 7, 1'b0, 1'b0);
    do_req("same_b_ch5", 1, 5, 1'b0, 1'b0);
    do_req("open_b_ch_ignored", 1, 7, 1'b1, 1'b0);
  endtask

  task automatic test_ignore_busy();
    do_req("busy_ignore_switch", 0, 3, 1'b0, 1'b1);
    do_req("busy_ignore_open", 0, 0, 1'b1, 1'b1);
    do_req("busy_ignore_b", 1, 2, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    logic [19:0] got;
    do_req("pre_mid_open", 0, 0, 1'b1, 1'b0);
    @(negedge clk);
    drive(0, 1'b1, 3, 1'b0);
    @(negedge clk);
    drive(0, 1'b0, 0, 1'b0);
    repeat (4) @(negedge clk);
    checks++;
    if (sw_a !== 4'b1000) begin
      errors++;
      $display("FAIL mid_pre_reset_sw actual=%b expected=1000", sw_a);
    end
    #2 rst = 1'b1;
    #1;
    got = obs(0);
    checks++;
    if (got !== 20'h0) begin
      errors++;
      $display("FAIL mid_async_clear actual=%h expected=%h", got, 20'h0);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({sw_a, done_a} !== 5'b0) begin
        errors++;
        $display("FAIL mid_reset_no_done cycle=%0d actual=%b expected=00000", k, {sw_a, done_a});
      end
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({ready_a, busy_a, sw_a} !== 6'b100000) begin
      errors++;
      $display("FAIL mid_release_ready actual=%b expected=100000", {ready_a, busy_a, sw_a});
    end
    cur[0] = -1;
    cur[1] = -1;
  endtask

  task automatic test_random();
    int w, ch, c;
    bit op;
    for (int i = 0; i < 40; i++) begin
      w  = int'($urandom_range(0, 1));
      c  = nch(w);
      op = ($urandom_range(0, 3) == 0);
      ch = (w == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 7));
      if (cur[w] >= 0 && $urandom_range(0, 3) == 0) ch = cur[w];
      do_req("random", w, ch, op, ($urandom_range(0, 4) == 0));
      if (c < 0) $display("unreachable");
    end
  endtask

`ifdef SWITCH_BANK_SWEEP_EN
  task automatic test_sweep();
    int s, c, step, total, j, i, exp_sw, pulses;
    logic [19:0] exp_v, got;
    s = 3; c = 4; step = 2 * s + 1; total = c * step + s + 1; pulses = 0;
    do_req("pre_sweep_switch", 0, 2, 1'b0, 1'b0);
    @(negedge clk);
    sweep_a = 1'b1;
    drive(0, 1'b1, 1, 1'b0);
    @(negedge clk);
    sweep_a = 1'b0;
    drive(0, 1'b0, 0, 1'b0);
    for (int k = 1; k <= total + 1; k++) begin
      if (k <= c * step) begin
        i = (k - 1) / step;
        j = (k - 1) % step + 1;
        exp_sw = (j <= s) ? 0 : (1 << i);
        exp_v  = pack(exp_sw, 1'b0, 1'b1, j == step, 1'b0);
      end else begin
        j = k - c * step;
        exp_v = pack(0, k > total, k <= total, j == s + 1, 1'b0);
      end
      got = obs(0);
      if (got[1]) pulses++;
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL sweep cycle=%0d actual={sw,rdy,bsy,dn,er}=%h expected=%h", k, got, exp_v);
      end
      if (k <= total) @(negedge clk);
    end
    checks++;
    if (pulses != c + 1) begin
      errors++;
      $display("FAIL sweep_done_count actual=%0d expected=%0d", pulses, c + 1);
    end
    cur[0] = -1;
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_illegal();
    test_ignore_busy();
    test_reset_mid();
    test_random();
`ifdef SWITCH_BANK_SWEEP_EN
    test_sweep();
`endif
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
